multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the program counter and datapath of the single-issue MIPS-like core.
- Latches the fetched opcode and steps through the states IF, ID, EXE, MEM and WB.
- Drives PCWre/PCSrc to the PC block, plus register-file, ALU and data-memory enables.
- Exactly one PCWre pulse retires each instruction.

Parameters:
- CNT_W, 32, width of the retired-instruction counter InstrCount.

Ports:
- CLK  in  1  system clock; all state updates on the posedge.
- Reset  in  1  synchronous, active-high reset.
- OpCode  in  6  instruction[31:26]; valid while the FSM is in IF.
- Zero  in  1  ALU zero flag; sampled only in EXE.
- PCWre  out  1  PC write enable; one-cycle pulse per instruction.
- PCSrc  out  2  00 = PC+4, 01 = branch (PC+4+imm<<2), 10 = jump target.
- IRWre  out  1  instruction register load; high in IF.
- RegWre  out  1  register-file write; high in WB only.
- RegDst  out  1  1 = rd (R-type), 0 = rt.
- ALUSrcB  out  1  1 = immediate operand.
- ALUOp  out  2  00 add, 01 sub, 10 use funct.
- MemRd  out  1  data-memory read; high in MEM for LW.
- MemWr  out  1  data-memory write; high in MEM for SW.
- DBDataSrc  out  1  1 = write-back data from memory.
- Halted  out  1  high while in HALT.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- InstrCount  out  CNT_W  number of retired instructions.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset high at a posedge → state = IF, op_q = 0, InstrCount = 0.
  - While Reset is high, every control output is forced to 0.
  - Reset takes priority over all transitions, including from HALT or mid-instruction (e.g. MEM). An aborted instruction is not counted and raises no PCWre.
- Opcodes (on op_q):
  - RTYPE 000000, ADDI 000001, J 000010, BEQ 000100, BNE 000101.
  - LW 100011, SW 101011, HALT 111111.
  - Anything else is illegal.
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- Outputs are combinational from state and op_q; state and op_q are registered.
- IF:
  - IRWre = 1.
  - op_q <= OpCode at the clock edge.
  - Next state: ID.
- ID:
  - J: PCWre = 1, PCSrc = 10 → IF.
  - HALT: → HALT, no PCWre.
  - Illegal opcode: PCWre = 1, PCSrc = 00, IllegalOp = 1 → IF.
  - All other opcodes → EXE.
- EXE:
  - ALUOp: 10 for RTYPE, 01 for BEQ/BNE, 00 otherwise.
  - ALUSrcB = 1 for ADDI/LW/SW.
  - BEQ: PCWre = 1, PCSrc = {1'b0, Zero} → IF.
  - BNE: PCWre = 1, PCSrc = {1'b0, ~Zero} → IF.
  - LW/SW → MEM.
  - RTYPE/ADDI → WB.
- MEM:
  - MemRd = 1 for LW; MemWr = 1 for SW.
  - SW: PCWre = 1, PCSrc = 00 → IF.
  - LW → WB.
- WB:
  - RegWre = 1.
  - RegDst = 1 for RTYPE.
  - DBDataSrc = 1 for LW.
  - PCWre = 1, PCSrc = 00 → IF.
- HALT:
  - Halted = 1; all other outputs 0.
  - Stays in HALT until Reset.
- PCSrc = 00 in every cycle where PCWre = 0.
- PCSrc = 11 is never driven.
- Latency (cycles from IF through the PCWre cycle):
  - J: 2; illegal opcode: 2.
  - BEQ/BNE: 3.
  - SW, RTYPE, ADDI: 4.
  - LW: 5.
- InstrCount:
  - Increments in every cycle where PCWre = 1; HALT does not count.
  - Wraps modulo 2^CNT_W without a flag.
- Zero is ignored in every state except EXE.

Optional Feature:
- Macro: CTRL_MEM_WAIT_EN.
- Defined:
  - Adds input MemReady (1 bit).
  - MEM holds while MemReady = 0, keeping MemRd/MemWr asserted.
  - MEM exits on the first cycle with MemReady = 1; the SW PCWre pulse occurs in that cycle.
  - Reset during a wait aborts to IF.
- Not defined:
  - No MemReady port.
  - MEM always lasts exactly one cycle.

Test Plan:
- Reset held 3 cycles, then released; OpCode = 000000 → IF, ID, EXE, WB. PCWre pulses only in cycle 4 with PCSrc = 00. RegWre = RegDst = 1 in WB. InstrCount = 1.
- BEQ with Zero = 1, then BEQ with Zero = 0 → PCSrc = 01 and then 00, each in the 3rd cycle with PCWre = 1. InstrCount += 2.
- J → PCWre = 1 and PCSrc = 10 in the ID cycle (2nd). No EXE cycle is observed.
- LW → MEM has MemRd = 1; WB has DBDataSrc = 1, RegWre = 1 and PCWre = 1 in cycle 5. SW → MemWr = 1 and PCWre = 1 in cycle 4, with RegWre never high.
- OpCode = 110000 → IllegalOp and PCWre both pulse in the ID cycle; next state IF. Then OpCode = 111111 → Halted = 1 indefinitely, PCWre = 0, InstrCount frozen. Reset → state IF, InstrCount = 0.
- With CTRL_MEM_WAIT_EN: SW with MemReady low for 3 cycles → MemWr held 4 cycles, PCWre only in the 4th MEM cycle. Reset asserted during the wait → IF, no PCWre, count unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS-like core.
// It sequences every instruction through IF/ID/EXE/MEM/WB. It drives the PC
// write enable and source select, plus the register-file, ALU and data-memory
// enables. Exactly one PCWre pulse retires each instruction, and InstrCount
// counts those pulses.
// Optional build macro: CTRL_MEM_WAIT_EN adds a MemReady input. While MemReady
// is low, the FSM waits in MEM with the memory strobes held.

module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [5:0]       OpCode,
   input  logic             Zero,
`ifdef CTRL_MEM_WAIT_EN
   input  logic             MemReady,
`endif
   output logic             PCWre,
   output logic [1:0]       PCSrc,
   output logic             IRWre,
   output logic             RegWre,
   output logic             RegDst,
   output logic             ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             MemRd,
   output logic             MemWr,
   output logic             DBDataSrc,
   output logic             Halted,
   output logic             IllegalOp,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EXE  = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [1:0] SRC_SEQ    = 2'b00;
   localparam logic [1:0] SRC_JUMP   = 2'b10;

   state_t           state;
   state_t           next_state;
   logic [5:0]       op_q;
   logic             mem_ready;

   logic             pc_wre;
   logic [1:0]       pc_src;
   logic             ir_wre;
   logic             reg_wre;
   logic             reg_dst;
   logic             alu_src_b;
   logic [1:0]       alu_op;
   logic             mem_rd;
   logic             mem_wr;
   logic             db_data_src;
   logic             halted;
   logic             illegal_op;
   logic [CNT_W-1:0] instr_count;

`ifdef CTRL_MEM_WAIT_EN
   assign mem_ready = MemReady;
`else
   assign mem_ready = 1'b1;
`endif

   // State register and opcode latch; the opcode is only captured in IF.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= ST_IF;
         op_q  <= 6'd0;
      end else begin
         state <= next_state;
         if (state == ST_IF) begin
            op_q <= OpCode;
         end
      end
   end

   // Next-state and raw control decode from the current state and latched opcode.
   always_comb begin
      next_state  = state;
      pc_wre      = 1'b0;
      pc_src      = SRC_SEQ;
      ir_wre      = 1'b0;
      reg_wre     = 1'b0;
      reg_dst     = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = 2'b00;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      db_data_src = 1'b0;
      halted      = 1'b0;
      illegal_op  = 1'b0;

      case (state)
         ST_IF: begin
            ir_wre     = 1'b1;
            next_state = ST_ID;
         end

         ST_ID: begin
            case (op_q)
               OP_J: begin
                  pc_wre     = 1'b1;
                  pc_src     = SRC_JUMP;
                  next_state = ST_IF;
               end
               OP_HALT: begin
                  next_state = ST_HALT;
               end
               OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW: begin
                  next_state = ST_EXE;
               end
               default: begin
                  pc_wre     = 1'b1;
                  pc_src     = SRC_SEQ;
                  illegal_op = 1'b1;
                  next_state = ST_IF;
               end
            endcase
         end

         ST_EXE: begin
            case (op_q)
               OP_RTYPE:         alu_op = 2'b10;
               OP_BEQ, OP_BNE:   alu_op = 2'b01;
               default:          alu_op = 2'b00;
            endcase
            alu_src_b = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
            case (op_q)
               OP_BEQ: begin
                  pc_wre     = 1'b1;
                  pc_src     = {1'b0, Zero};
                  next_state = ST_IF;
               end
               OP_BNE: begin
                  pc_wre     = 1'b1;
                  pc_src     = {1'b0, ~Zero};
                  next_state = ST_IF;
               end
               OP_LW, OP_SW: begin
                  next_state = ST_MEM;
               end
               OP_RTYPE, OP_ADDI: begin
                  next_state = ST_WB;
               end
               default: begin
                  next_state = ST_IF;
               end
            endcase
         end

         ST_MEM: begin
            mem_rd = (op_q == OP_LW);
            mem_wr = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_SW) begin
                  pc_wre     = 1'b1;
                  pc_src     = SRC_SEQ;
                  next_state = ST_IF;
               end else begin
                  next_state = ST_WB;
               end
            end
         end

         ST_WB: begin
            reg_wre     = 1'b1;
            reg_dst     = (op_q == OP_RTYPE);
            db_data_src = (op_q == OP_LW);
            pc_wre      = 1'b1;
            pc_src      = SRC_SEQ;
            next_state  = ST_IF;
         end

         ST_HALT: begin
            halted     = 1'b1;
            next_state = ST_HALT;
         end

         default: begin
            next_state = ST_IF;
         end
      endcase
   end

   // Retired-instruction counter; it wraps silently and clears on reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         instr_count <= '0;
      end else if (pc_wre) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Force every control output low while reset is held, whatever the state is.
   always_comb begin
      PCWre     = pc_wre      & ~Reset;
      PCSrc     = Reset ? 2'b00 : pc_src;
      IRWre     = ir_wre      & ~Reset;
      RegWre    = reg_wre     & ~Reset;
      RegDst    = reg_dst     & ~Reset;
      ALUSrcB   = alu_src_b   & ~Reset;
      ALUOp     = Reset ? 2'b00 : alu_op;
      MemRd     = mem_rd      & ~Reset;
      MemWr     = mem_wr      & ~Reset;
      DBDataSrc = db_data_src & ~Reset;
      Halted    = halted      & ~Reset;
      IllegalOp = illegal_op  & ~Reset;
   end

   assign InstrCount = instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Each instruction is described as a list of phases (fetch, decode, execute,
// memory, writeback, halted). The expected controls come from the phase, the
// opcode and whether this is the retiring cycle.
// The counter width is reduced to 4 bits so that wrap-around happens in a short run.

module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   logic             CLK = 1'b0;
   logic             Reset = 1'b1;
   logic [5:0]       OpCode = 6'd0;
   logic             Zero = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
   logic             MemReady = 1'b1;
`endif
   logic             PCWre;
   logic [1:0]       PCSrc;
   logic             IRWre;
   logic             RegWre;
   logic             RegDst;
   logic             ALUSrcB;
   logic [1:0]       ALUOp;
   logic             MemRd;
   logic             MemWr;
   logic             DBDataSrc;
   logic             Halted;
   logic             IllegalOp;
   logic [CNT_W-1:0] InstrCount;

   int tests = 0;
   int failures = 0;
   int retired = 0;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .OpCode     (OpCode),
      .Zero       (Zero),
`ifdef CTRL_MEM_WAIT_EN
      .MemReady   (MemReady),
`endif
      .PCWre      (PCWre),
      .PCSrc      (PCSrc),
      .IRWre      (IRWre),
      .RegWre     (RegWre),
      .RegDst     (RegDst),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .MemRd      (MemRd),
      .MemWr      (MemWr),
      .DBDataSrc  (DBDataSrc),
      .Halted     (Halted),
      .IllegalOp  (IllegalOp),
      .InstrCount (InstrCount)
   );

   // Free-running clock, period 10.
   always #5 CLK = ~CLK;

   // Watchdog so that the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] timeout");
   end

   function automatic bit isLegal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_ADDI, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_HALT};
   endfunction

   // The phase codes are 1 fetch, 2 decode, 3 execute, 4 memory, 5 writeback and 6 halted.
   // The packed order is PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp,
   // MemRd, MemWr, DBDataSrc, Halted, IllegalOp.
   function automatic logic [13:0] expectVec(input logic [5:0] op, input int phase,
                                             input bit last, input logic z);
      logic [1:0] src;
      logic [1:0] aluop;
      bit         immOp;
      src = 2'b00;
      if (last) begin
         if (op == OP_J)        src = 2'b10;
         else if (op == OP_BEQ) src = z ? 2'b01 : 2'b00;
         else if (op == OP_BNE) src = z ? 2'b00 : 2'b01;
      end
      aluop = 2'b00;
      if (phase == 3) begin
         if (op == OP_RTYPE) aluop = 2'b10;
         else if (op == OP_BEQ || op == OP_BNE) aluop = 2'b01;
      end
      immOp = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
      return {last, src, phase == 1, phase == 5, (phase == 5) && (op == OP_RTYPE),
              (phase == 3) && immOp, aluop, (phase == 4) && (op == OP_LW),
              (phase == 4) && (op == OP_SW), (phase == 5) && (op == OP_LW),
              phase == 6, (phase == 2) && !isLegal(op)};
   endfunction

   function automatic logic [13:0] observed();
      return {PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp,
              MemRd, MemWr, DBDataSrc, Halted, IllegalOp};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [13:0] exp);
      checkOutput({tag, " ctrl"}, 32'(observed()), 32'(exp));
      checkOutput({tag, " count"}, 32'(InstrCount), 32'(retired % (1 << CNT_W)));
   endtask

   // Hold reset for n cycles. The first check still sees the old count, because
   // the clearing edge has not happened yet.
   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         Reset  = 1'b1;
         OpCode = 6'($urandom);
         Zero   = 1'($urandom);
         #1;
         checkCycle($sformatf("reset c%0d", i), 14'd0);
         retired = 0;
      end
   endtask

   // Run one non-halting instruction from its IF cycle. The memory phase is stretched
   // by the given wait count in the wait build. Reset is raised at cycle index
   // abortAt (-1 means never). forceZero is -1 for a random flag, 0 or 1 otherwise.
   task automatic applyStimulus(input logic [5:0] op, input int waits, input int abortAt,
                                input int forceZero);
      int   phases[$];
      int   memCycles;
      int   memSeen;
      bit   last;
      phases = {1, 2};
`ifdef CTRL_MEM_WAIT_EN
      memCycles = waits + 1;
`else
      memCycles = 1 + 0 * waits;
`endif
      if (isLegal(op) && op != OP_J && op != OP_HALT) phases.push_back(3);
      if (op == OP_LW || op == OP_SW)
         for (int k = 0; k < memCycles; k++) phases.push_back(4);
      if (op == OP_RTYPE || op == OP_ADDI || op == OP_LW) phases.push_back(5);
      memSeen = 0;
      for (int i = 0; i < phases.size(); i++) begin
         @(negedge CLK);
         Reset  = (i == abortAt);
         OpCode = (phases[i] == 1) ? op : 6'($urandom);
         Zero   = (forceZero < 0) ? 1'($urandom) : forceZero[0];
`ifdef CTRL_MEM_WAIT_EN
         MemReady = (phases[i] == 4) ? (memSeen >= waits) : 1'($urandom);
`endif
         if (phases[i] == 4) memSeen++;
         #1;
         if (Reset) begin
            checkCycle($sformatf("abort op%0h c%0d", op, i), 14'd0);
            retired = 0;
            return;
         end
         last = (i == phases.size() - 1);
         checkCycle($sformatf("op%0h c%0d", op, i), expectVec(op, phases[i], last, Zero));
      end
      retired++;
   endtask

   // Fetch a HALT, check that it does not retire, then observe the stuck halted state.
   task automatic runHalt(input int holdCycles);
      for (int i = 0; i < holdCycles + 2; i++) begin
         @(negedge CLK);
         Reset  = 1'b0;
         OpCode = (i == 0) ? OP_HALT : 6'($urandom);
         Zero   = 1'($urandom);
         #1;
         checkCycle($sformatf("halt c%0d", i),
                    expectVec(OP_HALT, (i < 2) ? i + 1 : 6, 1'b0, Zero));
      end
   endtask

   // The directed sequence follows the test plan, then randomized instructions are run.
   initial begin
      logic [5:0] legalOps [7];
      logic [5:0] op;
      int         r;
      int         abortAt;
      legalOps = '{OP_RTYPE, OP_ADDI, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW};

      doReset(3);
      applyStimulus(OP_RTYPE, 0, -1, -1);
      applyStimulus(OP_BEQ, 0, -1, 1);
      applyStimulus(OP_BEQ, 0, -1, 0);
      applyStimulus(OP_BNE, 0, -1, 1);
      applyStimulus(OP_BNE, 0, -1, 0);
      applyStimulus(OP_J, 0, -1, -1);
      applyStimulus(OP_LW, 0, -1, -1);
      applyStimulus(OP_SW, 0, -1, -1);
      applyStimulus(6'b110000, 0, -1, -1);
      runHalt(5);
      doReset(2);
      applyStimulus(OP_ADDI, 0, -1, -1);
      applyStimulus(OP_LW, 0, 3, -1);
      applyStimulus(OP_SW, 0, -1, -1);
`ifdef CTRL_MEM_WAIT_EN
      applyStimulus(OP_SW, 3, -1, -1);
      applyStimulus(OP_LW, 2, -1, -1);
      applyStimulus(OP_SW, 3, 4, -1);
`endif

      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r == 9) begin
            runHalt($urandom_range(1, 3));
            doReset(1);
         end else begin
            if (r < 7) begin
               op = legalOps[r];
            end else begin
               op = 6'($urandom);
               while (isLegal(op)) op = 6'($urandom);
            end
            abortAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1;
            applyStimulus(op, $urandom_range(0, 3), abortAt, -1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
